burst_memory_reader: RTL

BURST_MEMORY_READER -- requirements
Module: burst_memory_reader

---
 rtl/burst_memory_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/burst_memory_reader.sv
`default_nettype none
// ============================================================================
// Module : burst_memory_reader
// Brief  : Arbitrated burst reader feeding a first-word-fall-through buffer.
//          BURST_READER_BUS_RELEASE_EN: release the bus while the buffer is full.
// Rev    : 1.0
// ============================================================================
module burst_memory_reader #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              done,
   output logic              arb_request,
   input  logic              arb_grant,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_rd_enable,
   input  logic              mem_busy,
   input  logic              mem_rd_ready,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_GRANT = 3'd1,
      ISSUE      = 3'd2,
      WAIT_DATA  = 3'd3,
      STALL      = 3'd4,
      DONE       = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_rem;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_CNT_W-1:0]  w_count_next;
   logic                w_push;
   logic                w_pop;
   logic                w_not_full;
   logic                w_rd_en;
   logic                w_drive;

   assign w_push       = (r_state == WAIT_DATA) && mem_rd_ready;
   assign out_valid    = (r_count != '0);
   assign w_pop        = out_valid && out_ready;
   assign w_not_full   = (r_count < c_DEPTH);
   assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
   assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;

   // Bus outputs float whenever another master may own the bus.
   assign w_drive       = arb_grant & nRst;
   assign mem_rd_addr   = w_drive ? r_addr  : {ADDR_W{1'bz}};
   assign mem_rd_enable = w_drive ? w_rd_en : 1'bz;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Remaining count of 0 means a full 2^LEN_W burst; the last word is at 1.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_addr <= '0;
         r_rem  <= '0;
      end else if ((r_state == IDLE) && req_valid) begin
         r_addr <= req_addr;
         r_rem  <= req_len;
      end else if (w_push) begin
         r_addr <= r_addr + ADDR_W'(1);
         r_rem  <= r_rem - LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= mem_rd_data;
   end

   always_comb begin
      w_next_state = r_state;
      req_ready    = 1'b0;
      arb_request  = 1'b0;
      done         = 1'b0;
      w_rd_en      = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next_state = WAIT_GRANT;
         end
         WAIT_GRANT: begin
`ifdef BURST_READER_BUS_RELEASE_EN
            arb_request = w_not_full;
`else
            arb_request = 1'b1;
`endif
            if (arb_grant) w_next_state = w_not_full ? ISSUE : STALL;
         end
         ISSUE: begin
            arb_request = 1'b1;
            w_rd_en     = 1'b1;
            if (!arb_grant)    w_next_state = WAIT_GRANT;
            else if (mem_busy) w_next_state = WAIT_DATA;
         end
         WAIT_DATA: begin
            // Returned data wins over a simultaneous grant loss so no word is dropped.
            arb_request = 1'b1;
            if (mem_rd_ready) begin
               if (r_rem == LEN_W'(1))          w_next_state = DONE;
               else if (w_count_next == c_DEPTH) w_next_state = STALL;
               else                              w_next_state = ISSUE;
            end else if (!arb_grant) begin
               w_next_state = WAIT_GRANT;
            end
         end
         STALL: begin
`ifdef BURST_READER_BUS_RELEASE_EN
            arb_request = 1'b0;
            if (w_not_full) w_next_state = WAIT_GRANT;
`else
            arb_request = 1'b1;
            if (!arb_grant)      w_next_state = WAIT_GRANT;
            else if (w_not_full) w_next_state = ISSUE;
`endif
         end
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule
`default_nettype wire
